// File: rtl/axilite_slave.sv
// AXI4-Lite slave over a DEPTH x DATA_WIDTH register memory with byte-strobed writes.
// Optional macro AXIL_ADDR_CHECK_EN: out-of-range addresses return SLVERR instead of wrapping.
module axilite_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int W     = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic                  awready_q, awready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  wr_en;
    logic                  wr_oor, rd_oor;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] mem_rd [DEPTH];

    assign wr_idx = s_axi_awaddr[IDX_W+W-1:W];
    assign rd_idx = s_axi_araddr[IDX_W+W-1:W];

`ifdef AXIL_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * BYTES);
    assign wr_oor = {1'b0, s_axi_awaddr} >= MEM_BYTES;
    assign rd_oor = {1'b0, s_axi_araddr} >= MEM_BYTES;
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    // Upper address bits only matter when range checking is compiled in.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    // Write channel: AW and W are only ever accepted together.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_state_d = W_ACK;
                    awready_d = 1'b1;
                end
            end
            W_ACK: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    wr_en     = !wr_oor;
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read data is sampled from the pre-edge memory, so a same-edge write is not visible.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    r_state_d = R_ACK;
                    arready_d = 1'b1;
                end
            end
            R_ACK: begin
                if (s_axi_arvalid) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_oor ? '0 : mem_rd[rd_idx];
                    rresp_d   = rd_oor ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    rresp_d   = RESP_OKAY;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Flop-based storage: the whole array must clear on reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_d, word_q;

            always_comb begin
                word_d = word_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (s_axi_wstrb[b]) begin
                            word_d[8*b +: 8] = s_axi_wdata[8*b +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign mem_rd[gi] = word_q;
        end
    endgenerate

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axilite_slave.sv
// Directed self-checking bench for axilite_slave (32-bit data, DEPTH 128).
module tb_axilite_slave;

    logic        clk;
    logic        rst_n;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int checks = 0;
    int errors = 0;

    axilite_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH     (128)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_awaddr (awaddr),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_bresp  (bresp),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_araddr (araddr),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        check("awready_pulse", awready, 1);
        check("wready_pulse", wready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("awready_drop", awready, 0);
        check("bvalid", bvalid, 1);
        check("bresp", bresp, resp);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        $display("write addr=%h data=%h strb=%b bresp=%b", addr, data, strb, resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] resp);
        araddr = addr; arvalid = 1'b1;
        @(posedge clk); #1;
        check("arready_pulse", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("arready_drop", arready, 0);
        check("rvalid", rvalid, 1);
        check("rdata", rdata, exp_data);
        check("rresp", rresp, resp);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
        $display("read  addr=%h rdata=%h expected=%h", addr, rdata, exp_data);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, awready, 0);
        check({tag, "_wready"}, wready, 0);
        check({tag, "_bvalid"}, bvalid, 0);
        check({tag, "_bresp"}, bresp, 0);
        check({tag, "_arready"}, arready, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_rresp"}, rresp, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
        arvalid = 0; araddr = 0; rready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word write then readback
        do_write(32'h04, 32'hAABBCCDD, 4'b1111, 2'b00);
        do_read (32'h04, 32'hAABBCCDD, 2'b00);

        // Single byte lane
        do_write(32'h04, 32'hAAAAAA11, 4'b0001, 2'b00);
        do_read (32'h04, 32'hAABBCC11, 2'b00);

        for (int i = 0; i < 5; i++) begin
            do_write(32'(i * 4), 32'h1000 + 32'(i), 4'b1111, 2'b00);
            do_read (32'(i * 4), 32'h1000 + 32'(i), 2'b00);
        end

`ifdef AXIL_ADDR_CHECK_EN
        do_write(32'h200, 32'hDEADBEEF, 4'b1111, 2'b10);
        do_read (32'h200, 32'h0, 2'b10);
        do_read (32'h000, 32'h1000, 2'b00);
        do_read (32'h004, 32'h1001, 2'b00);
`else
        do_write(32'h204, 32'hCAFE0204, 4'b1111, 2'b00);
        do_read (32'h004, 32'hCAFE0204, 2'b00);
        do_read (32'h204, 32'hCAFE0204, 2'b00);
`endif

        // Same-edge read and write to word 2: read returns old data
        awaddr = 32'h08; wdata = 32'h55555555; wstrb = 4'b1111;
        awvalid = 1; wvalid = 1; araddr = 32'h08; arvalid = 1;
        @(posedge clk); #1;
        check("coll_awready", awready, 1);
        check("coll_arready", arready, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("coll_bvalid", bvalid, 1);
        check("coll_rvalid", rvalid, 1);
        check("coll_rdata_old", rdata, 32'h1002);
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        $display("collision addr=08 rdata=%h expected=00001002", rdata);
        do_read(32'h08, 32'h55555555, 2'b00);

        // Asynchronous reset while responses are pending
        awaddr = 32'h10; wdata = 32'h77777777; wstrb = 4'b1111;
        awvalid = 1; wvalid = 1; araddr = 32'h08; arvalid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("pend_bvalid", bvalid, 1);
        check("pend_rvalid", rvalid, 1);
        check("pend_rdata", rdata, 32'h55555555);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        $display("async reset asserted mid-response");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(32'h10, 32'h0, 2'b00);
        do_read(32'h04, 32'h0, 2'b00);

        // Backpressure: responses held while new requests stay asserted
        araddr = 32'h08; arvalid = 1;
        awaddr = 32'h0C; wdata = 32'h12345678; wstrb = 4'b1111; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        check("bp_arready", arready, 1);
        check("bp_awready", awready, 1);
        @(posedge clk); #1;
        check("bp_rvalid", rvalid, 1);
        check("bp_bvalid", bvalid, 1);
        check("bp_rdata", rdata, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_rvalid", rvalid, 1);
            check("hold_bvalid", bvalid, 1);
            check("hold_rdata", rdata, 32'h0);
            check("hold_bresp", bresp, 2'b00);
            check("hold_arready", arready, 0);
            check("hold_awready", awready, 0);
            $display("hold cycle %0d rvalid=%b bvalid=%b arready=%b awready=%b",
                     k, rvalid, bvalid, arready, awready);
        end
        arvalid = 0; awvalid = 0; wvalid = 0;
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        check("bp_bvalid_clear", bvalid, 0);
        check("bp_rvalid_clear", rvalid, 0);
        do_read(32'h0C, 32'h12345678, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axilite_slave.md
Name: axilite_slave

Overview:
AXI4-Lite slave backed by a word-organised register memory of DEPTH words, DATA_WIDTH bits each. It supports single-beat writes with byte strobes and single-beat reads. It is used as a memory-mapped scratch RAM or peripheral register file behind an AXI-Lite interconnect. There is no burst, ID or PROT support.

Parameters:
- ADDR_WIDTH, 32: byte address width of AW/AR.
- DATA_WIDTH, 32: data bus width. Must be 32 or 64; strobe width is DATA_WIDTH/8.
- DEPTH, 128: number of memory words. Must be a power of two.

Ports:
- s_axi_aclk  in  1  clock; all logic on the rising edge
- s_axi_aresetn  in  1  reset, asynchronous assert, active-low
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  ADDR_WIDTH  write byte address
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables; bit n enables wdata[8n+7:8n]
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  ADDR_WIDTH  read byte address
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response (00 OKAY, 10 SLVERR)

Behaviour:
- Clock and reset: one clock, s_axi_aclk. Reset s_axi_aresetn is asynchronous and active-low.
- While reset is low:
  - all ready, valid and resp outputs and s_axi_rdata are 0;
  - every memory word is cleared to 0;
  - any in-flight transaction is discarded.
- Word index = addr[log2(DEPTH)+W-1 : W], where W = log2(DATA_WIDTH/8). Low W address bits are ignored.
- Write channel FSM states: W_IDLE, W_ACK, W_RESP.
  - W_IDLE: when awvalid and wvalid are both high, go to W_ACK. AW and W are accepted only together.
  - W_ACK: awready and wready are both high for exactly one cycle. At the end of this cycle (handshake edge), the memory byte lanes with wstrb set are updated; lanes with wstrb clear are unchanged.
  - W_RESP: bvalid is high with bresp valid. Hold bvalid and bresp stable until bready is high, then return to W_IDLE.
  - No new AW/W is accepted while bvalid is high.
  - Latency: valids seen → ready next cycle → bvalid on the cycle after the handshake.
- Read channel FSM states: R_IDLE, R_ACK, R_DATA.
  - R_IDLE: when arvalid is high, go to R_ACK.
  - R_ACK: arready is high for one cycle. rdata is captured from memory at the handshake edge.
  - R_DATA: rvalid is high. Hold rdata and rresp stable until rready is high, then return to R_IDLE.
  - No new AR is accepted while rvalid is high.
- Read and write channels are independent and may be active in the same cycle.
  - If AR and AW/W handshake on the same edge to the same word, the read returns the pre-write data.
- bresp/rresp are always 00 unless the optional feature below reports SLVERR.
- The master dropping valid before ready is a protocol violation. The slave then returns to IDLE without side effects.

Optional Feature:
- Macro: AXIL_ADDR_CHECK_EN.
- Defined: a byte address >= DEPTH*(DATA_WIDTH/8) is out of range.
  - Out-of-range write: no memory change, bresp=10.
  - Out-of-range read: rdata=0, rresp=10.
  - Handshake timing is unchanged.
- Not defined: upper address bits are ignored, so the address wraps modulo the memory size, and the response is always 00.

Test Plan:
- Write 0x04, data 0xAABBCCDD, strb 1111 → awready/wready pulse together for one cycle, then bvalid with bresp=00; read 0x04 → rdata=0xAABBCCDD, rresp=00.
- Write 0x04, data 0xAAAAAA11, strb 0001 → read 0x04 returns 0xAABBCC11.
- Loop i=0..4: write i*4 with 0x1000+i, strb 1111, then read i*4 → returns 0x00001000+i each time.
- After reset, read 0x08 without a prior write → rdata=0; hold bready/rready low for 5 cycles → bvalid/rvalid stay high with stable data and no further arready/awready pulses.
- With AXIL_ADDR_CHECK_EN: write 0x200 (DEPTH=128) → bresp=10 and memory unchanged; read 0x200 → rdata=0, rresp=10. Without the macro, writing 0x204 aliases word 1 (read 0x04 matches).
- Deassert s_axi_aresetn while bvalid or rvalid is pending → all outputs go to 0 immediately (asynchronously), memory is cleared, and the first transaction after release behaves normally.
